// File: rtl/branch_pred_unit.sv
// Branch resolve and direction predictor: decodes MIPS branches/jumps, resolves them
// against rs/rt, and trains a table of saturating counters indexed by the word PC.
module branch_pred_unit #(
    parameter int XLEN   = 32,
    parameter int IDX_W  = 6,
    parameter int CTR_W  = 2,
    parameter int MCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pred_valid,
    input  logic [XLEN-1:0]   pred_pc,
    output logic              pred_ack,
    output logic              pred_taken,
    input  logic              res_valid,
    input  logic [XLEN-1:0]   res_pc,
    input  logic [5:0]        op,
    input  logic [4:0]        rt_field,
    input  logic [5:0]        func,
    input  logic [XLEN-1:0]   rs,
    input  logic [XLEN-1:0]   rt,
    input  logic              res_pred_taken,
    output logic              res_done,
    output logic [1:0]        pc_src,
    output logic              taken,
    output logic              mispredict,
    output logic [MCNT_W-1:0] mispredict_cnt
);

    localparam int ENTRIES = 2 ** IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_MIN  = '0;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    localparam logic [1:0] SRC_PC4    = 2'b00;
    localparam logic [1:0] SRC_BRANCH = 2'b01;
    localparam logic [1:0] SRC_JUMP   = 2'b10;
    localparam logic [1:0] SRC_REG    = 2'b11;

    logic [CTR_W-1:0]  ctrTable_q [ENTRIES];
    logic              predAck_q, predTaken_q;
    logic              resDone_q, taken_q, mispredict_q;
    logic [1:0]        pcSrc_q;
    logic [MCNT_W-1:0] mispCnt_q;

    logic              isCond, taken_d, mispredict_d;
    logic [1:0]        pcSrc_d;
    logic [IDX_W-1:0]  resIdx, predIdx;
    logic [CTR_W-1:0]  resCtr, updCtr, lookCtr;
    logic              doUpdate;
    logic signed [XLEN-1:0] rsS, rtS;
    logic              unusedPcBits;

    assign rsS     = $signed(rs);
    assign rtS     = $signed(rt);
    assign resIdx  = res_pc[IDX_W+1:2];
    assign predIdx = pred_pc[IDX_W+1:2];
    assign unusedPcBits = ^{res_pc[XLEN-1:IDX_W+2], res_pc[1:0],
                            pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0]};

    always_comb begin
        isCond  = 1'b0;
        taken_d = 1'b0;
        pcSrc_d = SRC_PC4;
        case (op)
            OP_BEQ: begin
                isCond  = 1'b1;
                taken_d = (rsS == rtS);
            end
            OP_BNE: begin
                isCond  = 1'b1;
                taken_d = (rsS != rtS);
            end
            OP_BLEZ: begin
                isCond  = 1'b1;
                taken_d = (rsS <= 0);
            end
            OP_BGTZ: begin
                isCond  = 1'b1;
                taken_d = (rsS > 0);
            end
            OP_REGIMM: begin
                if (rt_field == 5'b00000) begin
                    isCond  = 1'b1;
                    taken_d = (rsS < 0);
                end else if (rt_field == 5'b00001) begin
                    isCond  = 1'b1;
                    taken_d = (rsS >= 0);
                end
            end
            OP_J, OP_JAL: begin
                taken_d = 1'b1;
                pcSrc_d = SRC_JUMP;
            end
            OP_SPECIAL: begin
                if (func == FN_JR || func == FN_JALR) begin
                    taken_d = 1'b1;
                    pcSrc_d = SRC_REG;
                end
            end
            default: ;
        endcase
        if (isCond && taken_d) begin
            pcSrc_d = SRC_BRANCH;
        end
        mispredict_d = taken_d ^ res_pred_taken;
    end

    // A lookup to the entry being trained this cycle sees the post-update counter.
    always_comb begin
        resCtr   = ctrTable_q[resIdx];
        doUpdate = res_valid && isCond;
        updCtr   = resCtr;
        if (taken_d) begin
            if (resCtr != CTR_MAX) begin
                updCtr = resCtr + 1'b1;
            end
        end else if (resCtr != CTR_MIN) begin
            updCtr = resCtr - 1'b1;
        end
        lookCtr = (doUpdate && (resIdx == predIdx)) ? updCtr : ctrTable_q[predIdx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctrTable_q[i] <= CTR_INIT;
            end
        end else if (doUpdate) begin
            ctrTable_q[resIdx] <= updCtr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            predAck_q   <= 1'b0;
            predTaken_q <= 1'b0;
        end else begin
            predAck_q <= pred_valid;
            if (pred_valid) begin
                predTaken_q <= lookCtr[CTR_W-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resDone_q    <= 1'b0;
            pcSrc_q      <= SRC_PC4;
            taken_q      <= 1'b0;
            mispredict_q <= 1'b0;
            mispCnt_q    <= '0;
        end else begin
            resDone_q <= res_valid;
            if (res_valid) begin
                pcSrc_q      <= pcSrc_d;
                taken_q      <= taken_d;
                mispredict_q <= mispredict_d;
                if (mispredict_d && !(&mispCnt_q)) begin
                    mispCnt_q <= mispCnt_q + 1'b1;
                end
            end
        end
    end

    assign pred_ack       = predAck_q;
    assign pred_taken     = predTaken_q;
    assign res_done       = resDone_q;
    assign pc_src         = pcSrc_q;
    assign taken          = taken_q;
    assign mispredict     = mispredict_q;
    assign mispredict_cnt = mispCnt_q;

endmodule

// File: tb/tb_branch_pred_unit.sv
// Scoreboard bench for branch_pred_unit: directed resolves/lookups queue their expected
// responses, and a monitor pops and compares whenever res_done or pred_ack appears.
module tb_branch_pred_unit;

    localparam int XLEN   = 32;
    localparam int IDX_W  = 6;
    localparam int CTR_W  = 2;
    localparam int MCNT_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pred_valid;
    logic [XLEN-1:0]   pred_pc;
    logic              pred_ack;
    logic              pred_taken;
    logic              res_valid;
    logic [XLEN-1:0]   res_pc;
    logic [5:0]        op;
    logic [4:0]        rt_field;
    logic [5:0]        func;
    logic [XLEN-1:0]   rs;
    logic [XLEN-1:0]   rt;
    logic              res_pred_taken;
    logic              res_done;
    logic [1:0]        pc_src;
    logic              taken;
    logic              mispredict;
    logic [MCNT_W-1:0] mispredict_cnt;

    typedef struct {
        logic [1:0]        src;
        logic              tk;
        logic              misp;
        logic [MCNT_W-1:0] cnt;
    } resExp_t;

    resExp_t           resQ[$];
    logic              predQ[$];
    int                testsRun = 0;
    int                testsFailed = 0;
    logic [MCNT_W-1:0] modelCnt = '0;
    bit                done = 1'b0;

    branch_pred_unit #(
        .XLEN(XLEN), .IDX_W(IDX_W), .CTR_W(CTR_W), .MCNT_W(MCNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_ack(pred_ack), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_pc(res_pc), .op(op), .rt_field(rt_field),
        .func(func), .rs(rs), .rt(rt), .res_pred_taken(res_pred_taken),
        .res_done(res_done), .pc_src(pc_src), .taken(taken),
        .mispredict(mispredict), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drives one resolve for the next edge and queues its hand-derived result.
    task automatic issueResolve(input logic [31:0] pc, input logic [5:0] opc,
                                input logic [4:0] rtf, input logic [5:0] fn,
                                input logic [31:0] rsv, input logic [31:0] rtv,
                                input logic predT, input logic [1:0] expSrc,
                                input logic expTaken);
        resExp_t e;
        res_valid      = 1'b1;
        res_pc         = pc;
        op             = opc;
        rt_field       = rtf;
        func           = fn;
        rs             = rsv;
        rt             = rtv;
        res_pred_taken = predT;
        e.src  = expSrc;
        e.tk   = expTaken;
        e.misp = expTaken ^ predT;
        if (e.misp && modelCnt != '1) modelCnt = modelCnt + 1'b1;
        e.cnt  = modelCnt;
        resQ.push_back(e);
    endtask

    task automatic issueLookup(input logic [31:0] pc, input logic expTaken);
        pred_valid = 1'b1;
        pred_pc    = pc;
        predQ.push_back(expTaken);
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
        pred_valid = 1'b0;
        res_valid  = 1'b0;
    endtask

    task automatic monitor();
        resExp_t e;
        logic    p;
        while (!done) begin
            @(negedge clk);
            if (rst_n) begin
                if (res_done) begin
                    if (resQ.size() == 0) begin
                        checkOutput("unexpected_res_done", 32'd1, 32'd0);
                    end else begin
                        e = resQ.pop_front();
                        checkOutput("pc_src", 32'(pc_src), 32'(e.src));
                        checkOutput("taken", 32'(taken), 32'(e.tk));
                        checkOutput("mispredict", 32'(mispredict), 32'(e.misp));
                        checkOutput("mispredict_cnt", 32'(mispredict_cnt), 32'(e.cnt));
                    end
                end
                if (pred_ack) begin
                    if (predQ.size() == 0) begin
                        checkOutput("unexpected_pred_ack", 32'd1, 32'd0);
                    end else begin
                        p = predQ.pop_front();
                        checkOutput("pred_taken", 32'(pred_taken), 32'(p));
                    end
                end
            end
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_pred_ack"}, 32'(pred_ack), 32'd0);
        checkOutput({tag, "_pred_taken"}, 32'(pred_taken), 32'd0);
        checkOutput({tag, "_res_done"}, 32'(res_done), 32'd0);
        checkOutput({tag, "_pc_src"}, 32'(pc_src), 32'd0);
        checkOutput({tag, "_taken"}, 32'(taken), 32'd0);
        checkOutput({tag, "_mispredict"}, 32'(mispredict), 32'd0);
        checkOutput({tag, "_mispredict_cnt"}, 32'(mispredict_cnt), 32'd0);
    endtask

    task automatic mainSequence();
        rst_n = 1'b0;
        pred_valid = 1'b0; pred_pc = '0;
        res_valid = 1'b0; res_pc = '0; op = '0; rt_field = '0; func = '0;
        rs = '0; rt = '0; res_pred_taken = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;

        // Decode sweep, back-to-back, pc 0x200 aliases to index 0.
        issueResolve(32'h200, 6'd0, 5'd1, 6'b001001, -32'sd4, 32'd12, 1'b0, 2'b11, 1'b1); applyStimulus();
        issueResolve(32'h200, 6'd1, 5'd1, 6'b001001, -32'sd4, 32'd12, 1'b0, 2'b00, 1'b0); applyStimulus();
        issueResolve(32'h200, 6'd2, 5'd1, 6'b001001, -32'sd4, 32'd12, 1'b0, 2'b10, 1'b1); applyStimulus();
        issueResolve(32'h200, 6'd3, 5'd1, 6'b001001, -32'sd4, 32'd12, 1'b0, 2'b10, 1'b1); applyStimulus();
        issueResolve(32'h200, 6'd4, 5'd1, 6'b001001, -32'sd4, 32'd12, 1'b0, 2'b00, 1'b0); applyStimulus();
        issueResolve(32'h200, 6'd5, 5'd1, 6'b001001, -32'sd4, 32'd12, 1'b0, 2'b01, 1'b1); applyStimulus();
        issueResolve(32'h200, 6'd6, 5'd1, 6'b001001, -32'sd4, 32'd12, 1'b0, 2'b01, 1'b1); applyStimulus();
        issueResolve(32'h200, 6'd7, 5'd1, 6'b001001, -32'sd4, 32'd12, 1'b0, 2'b00, 1'b0); applyStimulus();
        issueResolve(32'h3C0, 6'd1, 5'd2, 6'd0, -32'sd4, 32'd0, 1'b1, 2'b00, 1'b0); applyStimulus();
        issueResolve(32'h3C0, 6'd1, 5'd0, 6'd0, -32'sd4, 32'd0, 1'b1, 2'b01, 1'b1); applyStimulus();
        issueResolve(32'h3C4, 6'd0, 5'd0, 6'b001000, 32'd7, 32'd0, 1'b1, 2'b11, 1'b1); applyStimulus();
        issueResolve(32'h3C4, 6'd0, 5'd0, 6'b100000, 32'd7, 32'd0, 1'b0, 2'b00, 1'b0); applyStimulus();

        // Counter saturation at pc 0x40: 01 -> 10 -> 11 -> 11 -> 11.
        repeat (4) begin
            issueResolve(32'h40, 6'd4, 5'd0, 6'd0, 32'd5, 32'd5, 1'b1, 2'b01, 1'b1); applyStimulus();
        end
        issueLookup(32'h40, 1'b1); applyStimulus();
        applyStimulus();
        @(negedge clk);
        checkOutput("idle_pred_ack", 32'(pred_ack), 32'd0);
        checkOutput("hold_pred_taken", 32'(pred_taken), 32'd1);
        repeat (3) begin
            issueResolve(32'h40, 6'd4, 5'd0, 6'd0, 32'd5, 32'd6, 1'b0, 2'b00, 1'b0); applyStimulus();
        end
        issueLookup(32'h40, 1'b0); applyStimulus();
        issueResolve(32'h40, 6'd4, 5'd0, 6'd0, 32'd5, 32'd5, 1'b1, 2'b01, 1'b1); applyStimulus();
        issueLookup(32'h40, 1'b0); applyStimulus();

        // Write bypass: entry 0x80 at 01, taken bne with same-cycle lookup.
        issueResolve(32'h80, 6'd5, 5'd0, 6'd0, 32'd1, 32'd2, 1'b0, 2'b01, 1'b1);
        issueLookup(32'h80, 1'b1);
        applyStimulus();

        // Aliasing: index 0 is at 01 after the sweep; 0x100 shares it, 0x004 does not.
        issueResolve(32'h000, 6'd4, 5'd0, 6'd0, 32'd0, 32'd0, 1'b0, 2'b01, 1'b1); applyStimulus();
        issueLookup(32'h100, 1'b1); applyStimulus();
        issueLookup(32'h004, 1'b0); applyStimulus();

        // Reset in the cycle after an in-flight resolve and lookup.
        res_valid = 1'b1; res_pc = 32'h0; op = 6'd4; rt_field = '0; func = '0;
        rs = 32'd0; rt = 32'd0; res_pred_taken = 1'b0;
        pred_valid = 1'b1; pred_pc = 32'h100;
        applyStimulus();
        rst_n = 1'b0;
        modelCnt = '0;
        #1;
        checkAllZero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_res_done", 32'(res_done), 32'd0);
        checkOutput("post_reset_pred_ack", 32'(pred_ack), 32'd0);
        // Entry 0 back at 01: a not-taken update drops it to 00.
        issueResolve(32'h000, 6'd4, 5'd0, 6'd0, 32'd0, 32'd1, 1'b0, 2'b00, 1'b0); applyStimulus();
        issueLookup(32'h100, 1'b0); applyStimulus();

        // Twenty mispredicting jumps saturate the 4-bit count at 15.
        repeat (20) begin
            issueResolve(32'h10, 6'd2, 5'd0, 6'd0, 32'd0, 32'd0, 1'b0, 2'b10, 1'b1); applyStimulus();
        end
        repeat (3) applyStimulus();
        @(negedge clk);
        checkOutput("final_mispredict_cnt", 32'(mispredict_cnt), 32'd15);
        checkOutput("res_queue_drained", 32'(resQ.size()), 32'd0);
        checkOutput("pred_queue_drained", 32'(predQ.size()), 32'd0);
        done = 1'b1;
    endtask

    initial begin
        fork
            monitor();
            mainSequence();
        join
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
